// File: rtl/cache_mgmt_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mgmt_unit
//  Purpose  : Controller between the CPU memory stage and a 2-way
//             set-associative cache array. Hits complete through the array's
//             load/edit strobes. Misses write back a dirty victim line
//             word-by-word, refill the line from memory over an ack handshake,
//             then replay the original request so that it hits.
//  Ports    :
//    clk, rst                 clock, synchronous active-high reset
//    addr_rw, en_r, en_w      CPU byte address and read/write requests
//    u_b_h_w, data_w          RV32I funct3 width/sign code, CPU write data
//    data_r, stall, done      CPU read data, hold-request, completion pulse
//    cache_addr/load/edit/store/invalid/ubhw/din   array control
//    cache_hit/valid/dirty/tag/dout                registered array results
//    mem_cs/we/addr/dout, mem_din/ack              word-serial memory port
//    hit_cnt, miss_cnt        free-running wrap-around statistics
//  Revision : 1.0  initial release
// ============================================================================
module cache_mgmt_unit #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 23,
    parameter int INDEX_BITS = 5,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU side
    input  logic [ADDR_BITS-1:0]  addr_rw,
    input  logic                  en_r,
    input  logic                  en_w,
    input  logic [2:0]            u_b_h_w,
    input  logic [31:0]           data_w,
    output logic [31:0]           data_r,
    output logic                  stall,
    output logic                  done,
    // cache array side
    output logic [ADDR_BITS-1:0]  cache_addr,
    output logic                  cache_load,
    output logic                  cache_edit,
    output logic                  cache_store,
    output logic                  cache_invalid,
    output logic [2:0]            cache_ubhw,
    output logic [31:0]           cache_din,
    input  logic                  cache_hit,
    input  logic                  cache_valid,
    input  logic                  cache_dirty,
    input  logic [TAG_BITS-1:0]   cache_tag,
    input  logic [31:0]           cache_dout,
    // memory side
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [31:0]           mem_dout,
    input  logic [31:0]           mem_din,
    input  logic                  mem_ack,
    // statistics
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int OFF_BITS  = ADDR_BITS - TAG_BITS - INDEX_BITS;
    localparam int WSEL_BITS = $clog2(LINE_WORDS);
    localparam logic [WSEL_BITS-1:0] LAST_K = WSEL_BITS'(LINE_WORDS - 1);
    localparam logic [2:0] C_UBHW_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB_RD  = 3'd2,
        S_WB_WR  = 3'd3,
        S_FILL   = 3'd4,
        S_REPLAY = 3'd5
    } state_t;

    state_t                 r_state;
    logic [ADDR_BITS-1:0]   r_req_addr;
    logic                   r_req_write;
    logic [2:0]             r_req_ubhw;
    logic [31:0]            r_req_data;
    logic [TAG_BITS-1:0]    r_victim_tag;
    logic [WSEL_BITS-1:0]   r_k;
    logic                   r_replayed;   // current request already refilled once
    logic [31:0]            r_data_hold;  // last read result, shown when no read completes
    logic [31:0]            r_hit_cnt;
    logic [31:0]            r_miss_cnt;

    logic [INDEX_BITS-1:0]  w_req_index;
    logic [TAG_BITS-1:0]    w_req_tag;
    logic [ADDR_BITS-1:0]   w_line_word_addr;
    logic [ADDR_BITS-1:0]   w_fill_addr;
    logic [ADDR_BITS-1:0]   w_wb_addr;
    logic                   w_read_done;

    assign w_req_index      = r_req_addr[OFF_BITS +: INDEX_BITS];
    assign w_req_tag        = r_req_addr[ADDR_BITS-1 -: TAG_BITS];
    assign w_line_word_addr = {r_req_addr[ADDR_BITS-1:OFF_BITS], r_k, 2'b00};
    assign w_fill_addr      = {w_req_tag, w_req_index, r_k, 2'b00};
    assign w_wb_addr        = {r_victim_tag, w_req_index, r_k, 2'b00};

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_addr   <= '0;
            r_req_write  <= 1'b0;
            r_req_ubhw   <= '0;
            r_req_data   <= '0;
            r_victim_tag <= '0;
            r_k          <= '0;
            r_replayed   <= 1'b0;
            r_data_hold  <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The request is sampled every idle cycle; the copy taken
                    // on the cycle it leaves IDLE is the one that sticks.
                    r_req_addr  <= addr_rw;
                    r_req_write <= en_w;
                    r_req_ubhw  <= u_b_h_w;
                    r_req_data  <= data_w;
                    r_replayed  <= 1'b0;
                    if (en_r | en_w) begin
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        // A replayed lookup completes a miss, not a new hit.
                        if (!r_replayed) begin
                            r_hit_cnt <= r_hit_cnt + 32'd1;
                        end
                        if (!r_req_write) begin
                            r_data_hold <= cache_dout;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        if (!r_replayed) begin
                            r_miss_cnt <= r_miss_cnt + 32'd1;
                        end
                        r_victim_tag <= cache_tag;
                        r_k          <= '0;
                        r_state      <= (cache_valid && cache_dirty) ? S_WB_RD : S_FILL;
                    end
                end
                S_WB_RD: begin
                    r_state <= S_WB_WR;
                end
                S_WB_WR: begin
                    if (mem_ack) begin
                        if (r_k == LAST_K) begin
                            r_k     <= '0;
                            r_state <= S_FILL;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_WB_RD;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        if (r_k == LAST_K) begin
                            r_k     <= '0;
                            r_state <= S_REPLAY;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_REPLAY: begin
                    r_replayed <= 1'b1;
                    r_state    <= S_LOOKUP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is held at zero while reset is asserted so
    // an in-flight memory request is withdrawn immediately.
    // ------------------------------------------------------------------
    always_comb begin
        cache_addr  = '0;
        cache_load  = 1'b0;
        cache_edit  = 1'b0;
        cache_store = 1'b0;
        cache_ubhw  = '0;
        cache_din   = '0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_dout    = '0;
        done        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    cache_addr = addr_rw;
                    cache_load = en_r & ~en_w;
                    cache_edit = en_w;
                    cache_ubhw = u_b_h_w;
                    cache_din  = data_w;
                end
                S_LOOKUP: begin
                    cache_addr = r_req_addr;
                    cache_ubhw = r_req_ubhw;
                    done       = cache_hit;
                end
                S_WB_RD: begin
                    // load=0: the array presents the victim way's word.
                    cache_addr = w_line_word_addr;
                    cache_ubhw = C_UBHW_WORD;
                end
                S_WB_WR: begin
                    cache_addr = w_line_word_addr;
                    cache_ubhw = C_UBHW_WORD;
                    mem_cs     = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = w_wb_addr;
                    mem_dout   = cache_dout;
                end
                S_FILL: begin
                    cache_addr  = w_fill_addr;
                    cache_ubhw  = C_UBHW_WORD;
                    cache_store = mem_ack;
                    cache_din   = mem_din;
                    mem_cs      = 1'b1;
                    mem_addr    = w_fill_addr;
                end
                S_REPLAY: begin
                    cache_addr = r_req_addr;
                    cache_load = ~r_req_write;
                    cache_edit = r_req_write;
                    cache_ubhw = r_req_ubhw;
                    cache_din  = r_req_data;
                end
                default: begin
                    cache_addr = '0;
                end
            endcase
        end
    end

    assign w_read_done   = done & ~r_req_write;
    assign data_r        = w_read_done ? cache_dout : r_data_hold;
    assign stall         = (en_r | en_w) & ~done;
    assign cache_invalid = 1'b0;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule
`default_nettype wire
